fall_monitor_array: RTL and testbench

//  Multi-channel successor to fall_detection_system: N_CH independent fall sensors, each with

---
 rtl/fall_pkg.sv | 29 ++
 rtl/fall_monitor_array_channel.sv | 173 +++++++++++++++++
 rtl/fall_monitor_array.sv | 73 +++++++
 tb/tb_fall_monitor_array.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fall_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fall_pkg
// Purpose  : Shared types and helpers for the fall monitor array. Holds the
//            per-channel state type and the parameter legality check that
//            the top level evaluates at elaboration.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package fall_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FALL  = 2'd1,
    WARN  = 2'd2,
    ALARM = 2'd3
  } fall_state_t;

  // Legal configuration: 1..16 channels, 0 < WARN_S < ALARM_S, non-zero
  // clock rate and debounce length.
  function automatic bit cfg_ok(input int n_ch, input int clk_hz,
                                input int warn_s, input int alarm_s,
                                input int debounce_cyc);
    return (n_ch >= 1) && (n_ch <= 16) && (clk_hz >= 1) &&
           (warn_s > 0) && (warn_s < alarm_s) && (debounce_cyc >= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fall_monitor_array_channel.sv
`default_nettype none
// ============================================================================
// Module   : fall_channel_fsm
// Purpose  : One fall-monitor channel: 2-flop synchroniser, debounce, cycle
//            prescaler + seconds counter, and the IDLE/FALL/WARN/ALARM FSM.
// Ports    : clk, reset_n        clock, async active-low reset
//            fall_sensor         raw asynchronous sensor level (1 = fallen)
//            patient_reset       patient cancel, synchronous to clk
//            caregiver_ack       clears a latched alarm
//            warn, alarm         registered pre-alarm / latched alarm
//            cancel_pulse        1-cycle pulse when a fall is cancelled
// Revision : 1.0  initial release
// ============================================================================
module fall_channel_fsm
  import fall_pkg::*;
#(
  parameter int CLK_HZ       = 1000000,
  parameter int WARN_S       = 20,
  parameter int ALARM_S      = 30,
  parameter int DEBOUNCE_CYC = 16,
  parameter int AUTO_CLEAR   = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fall_sensor,
  input  logic patient_reset,
  input  logic caregiver_ack,
  output logic warn,
  output logic alarm,
  output logic cancel_pulse
);

  localparam int c_PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int c_SEC_W = $clog2(ALARM_S + 1);
  localparam int c_DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [c_PRE_W-1:0] c_PRE_LAST       = c_PRE_W'(CLK_HZ - 1);
  localparam logic [c_SEC_W-1:0] c_WARN_SEC_LAST  = c_SEC_W'(WARN_S - 1);
  localparam logic [c_SEC_W-1:0] c_ALARM_SEC_LAST = c_SEC_W'(ALARM_S - 1);
  localparam logic [c_SEC_W-1:0] c_ALARM_SEC      = c_SEC_W'(ALARM_S);
  localparam logic [c_DB_W-1:0]  c_DB_LAST        = c_DB_W'(DEBOUNCE_CYC - 1);
  localparam bit                 c_AUTO_CLEAR     = (AUTO_CLEAR != 0);

  logic [1:0]         r_sync;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic               r_valid;
  logic               r_valid_d;
  logic [c_PRE_W-1:0] r_pre;
  logic [c_SEC_W-1:0] r_sec;
  fall_state_t        r_state;
  logic               r_warn;
  logic               r_alarm;
  logic               r_cancel;

  fall_state_t        w_state_nxt;
  logic               w_cancel_nxt;
  logic               w_cnt_en;
  logic               w_rise;
  logic               w_cancel_req;
  logic               w_pre_wrap;
  logic               w_hit_warn;
  logic               w_hit_alarm;

  // --------------------------------------------------------------------------
  // Input synchroniser and debounce. The counter tracks how many consecutive
  // synced samples disagree with the accepted level; any agreeing sample
  // restarts it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b00;
      r_db_cnt  <= '0;
      r_valid   <= 1'b0;
      r_valid_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], fall_sensor};
      r_valid_d <= r_valid;
      if (r_sync[1] == r_valid) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        r_valid  <= r_sync[1];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DB_W'(1);
      end
    end
  end

  // Only a fresh rising edge of the debounced level starts a fall; a level
  // still high after a cancel or an acknowledge does not.
  assign w_rise       = r_valid & ~r_valid_d;
  assign w_cancel_req = patient_reset | (c_AUTO_CLEAR & ~r_valid);

  // Thresholds are tested on the elapsed count before the increment, so the
  // registered outputs become visible exactly at the threshold cycle.
  assign w_pre_wrap  = (r_pre == c_PRE_LAST);
  assign w_hit_warn  = w_pre_wrap && (r_sec == c_WARN_SEC_LAST);
  assign w_hit_alarm = w_pre_wrap && (r_sec == c_ALARM_SEC_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic. Cancel is evaluated ahead of the thresholds so that a
  // coincident cancel wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = FALL;
      end
      FALL: begin
        if (w_cancel_req) begin
          w_state_nxt  = IDLE;
          w_cancel_nxt = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
          if (w_hit_warn) w_state_nxt = WARN;
        end
      end
      WARN: begin
        if (w_cancel_req) begin
          w_state_nxt  = IDLE;
          w_cancel_nxt = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
          if (w_hit_alarm) w_state_nxt = ALARM;
        end
      end
      ALARM: begin
        if (caregiver_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and registered outputs. Counters are held at zero while
  // idle so that entry into FALL starts from elapsed = 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_pre    <= '0;
      r_sec    <= '0;
      r_warn   <= 1'b0;
      r_alarm  <= 1'b0;
      r_cancel <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_warn   <= (w_state_nxt == WARN);
      r_alarm  <= (w_state_nxt == ALARM);
      r_cancel <= w_cancel_nxt;
      if (r_state == IDLE) begin
        r_pre <= '0;
        r_sec <= '0;
      end else if (w_cnt_en) begin
        if (w_pre_wrap) begin
          r_pre <= '0;
          r_sec <= (r_sec == c_ALARM_SEC) ? r_sec : r_sec + c_SEC_W'(1);
        end else begin
          r_pre <= r_pre + c_PRE_W'(1);
        end
      end
    end
  end

  assign warn         = r_warn;
  assign alarm        = r_alarm;
  assign cancel_pulse = r_cancel;

endmodule
`default_nettype wire

// File: rtl/fall_monitor_array.sv
`default_nettype none
// ============================================================================
// Module   : fall_monitor_array
// Purpose  : N_CH independent fall-monitor channels feeding the ward alarm
//            panel, plus an alarm OR and a count of channels in alarm.
// Ports    : clk, reset_n                  clock, async active-low reset
//            fall_sensor   [N_CH]          raw sensor levels, 1 = fallen
//            patient_reset [N_CH]          patient cancel
//            caregiver_ack [N_CH]          caregiver clears a latched alarm
//            warn, alarm   [N_CH]          per-channel pre-alarm / alarm
//            alarm_any                     OR of alarm
//            alarm_count                   number of channels in alarm
//            cancel_pulse  [N_CH]          1-cycle cancel indication
// Revision : 1.0  initial release
// ============================================================================
module fall_monitor_array
  import fall_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CLK_HZ       = 1000000,
  parameter int WARN_S       = 20,
  parameter int ALARM_S      = 30,
  parameter int DEBOUNCE_CYC = 16,
  parameter int AUTO_CLEAR   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_CH-1:0]           fall_sensor,
  input  logic [N_CH-1:0]           patient_reset,
  input  logic [N_CH-1:0]           caregiver_ack,
  output logic [N_CH-1:0]           warn,
  output logic [N_CH-1:0]           alarm,
  output logic                      alarm_any,
  output logic [$clog2(N_CH+1)-1:0] alarm_count,
  output logic [N_CH-1:0]           cancel_pulse
);

  localparam int c_CNT_W = $clog2(N_CH + 1);

  if (!cfg_ok(N_CH, CLK_HZ, WARN_S, ALARM_S, DEBOUNCE_CYC)) begin : g_cfg_error
    $error("fall_monitor_array: illegal parameter combination");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fall_channel_fsm #(
      .CLK_HZ       (CLK_HZ),
      .WARN_S       (WARN_S),
      .ALARM_S      (ALARM_S),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .AUTO_CLEAR   (AUTO_CLEAR)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .fall_sensor   (fall_sensor[g]),
      .patient_reset (patient_reset[g]),
      .caregiver_ack (caregiver_ack[g]),
      .warn          (warn[g]),
      .alarm         (alarm[g]),
      .cancel_pulse  (cancel_pulse[g])
    );
  end

  assign alarm_any = |alarm;

  always_comb begin
    alarm_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      alarm_count = alarm_count + c_CNT_W'(alarm[i]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fall_monitor_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_fall_monitor_array
// Purpose  : Self-checking bench for fall_monitor_array: directed scenarios
//            followed by randomised traffic, every cycle compared with a
//            behavioural model that tracks elapsed fall time as one integer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fall_monitor_array;

  localparam int NC        = 4;
  localparam int HZ        = 10;
  localparam int WS        = 2;
  localparam int AS        = 3;
  localparam int DB        = 4;
  localparam int AC        = 1;
  localparam int CW        = $clog2(NC + 1);
  localparam int WARN_CYC  = WS * HZ;
  localparam int ALARM_CYC = AS * HZ;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NC-1:0] fall_sensor = '0;
  logic [NC-1:0] patient_reset = '0;
  logic [NC-1:0] caregiver_ack = '0;
  logic [NC-1:0] warn;
  logic [NC-1:0] alarm;
  logic          alarm_any;
  logic [CW-1:0] alarm_count;
  logic [NC-1:0] cancel_pulse;

  always #5 clk = ~clk;

  fall_monitor_array #(
    .N_CH(NC), .CLK_HZ(HZ), .WARN_S(WS), .ALARM_S(AS),
    .DEBOUNCE_CYC(DB), .AUTO_CLEAR(AC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fall_sensor   (fall_sensor),
    .patient_reset (patient_reset),
    .caregiver_ack (caregiver_ack),
    .warn          (warn),
    .alarm         (alarm),
    .alarm_any     (alarm_any),
    .alarm_count   (alarm_count),
    .cancel_pulse  (cancel_pulse)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model. raw[c][0] is the sensor value sampled at the previous
  // edge; the debounce at an edge looks at samples two to DB+1 edges old.
  // --------------------------------------------------------------------------
  bit raw      [NC][DB+1];
  bit m_lvl    [NC];
  bit m_lvl_pv [NC];
  bit m_active [NC];
  bit m_alarm  [NC];
  bit m_cancel [NC];
  int m_elapsed[NC];

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k <= DB; k++) raw[c][k] = 1'b0;
      m_lvl[c] = 0; m_lvl_pv[c] = 0; m_active[c] = 0;
      m_alarm[c] = 0; m_cancel[c] = 0; m_elapsed[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit all_new;
    for (int c = 0; c < NC; c++) begin
      m_cancel[c] = 0;
      if (m_alarm[c]) begin
        if (caregiver_ack[c]) m_alarm[c] = 0;
      end else if (m_active[c]) begin
        if (patient_reset[c] || (AC != 0 && !m_lvl[c])) begin
          m_active[c] = 0;
          m_cancel[c] = 1;
        end else begin
          m_elapsed[c]++;
          if (m_elapsed[c] == ALARM_CYC) begin
            m_active[c] = 0;
            m_alarm[c]  = 1;
          end
        end
      end else if (m_lvl[c] && !m_lvl_pv[c]) begin
        m_active[c]  = 1;
        m_elapsed[c] = 0;
      end
      m_lvl_pv[c] = m_lvl[c];
      all_new = 1;
      for (int k = 1; k <= DB; k++) if (raw[c][k] == m_lvl[c]) all_new = 0;
      if (all_new) m_lvl[c] = ~m_lvl[c];
      for (int k = DB; k > 0; k--) raw[c][k] = raw[c][k-1];
      raw[c][0] = fall_sensor[c];
    end
  endtask

  task automatic check_all(input string tag);
    logic [NC-1:0] ew, ea, ec;
    int cnt;
    cnt = 0;
    for (int c = 0; c < NC; c++) begin
      ew[c] = m_active[c] && (m_elapsed[c] >= WARN_CYC);
      ea[c] = m_alarm[c];
      ec[c] = m_cancel[c];
      cnt += int'(m_alarm[c]);
    end
    check_eq({tag, ".warn"},   32'(warn),         32'(ew));
    check_eq({tag, ".alarm"},  32'(alarm),        32'(ea));
    check_eq({tag, ".cancel"}, 32'(cancel_pulse), 32'(ec));
    check_eq({tag, ".any"},    32'(alarm_any),    32'(cnt != 0));
    check_eq({tag, ".count"},  32'(alarm_count),  32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1 check_all("cyc");
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Reset asserted mid-cycle, away from any edge.
  task automatic async_reset(input int hold);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    check_eq("rst.alarm_zero",  32'(alarm),        32'd0);
    check_eq("rst.cancel_zero", 32'(cancel_pulse), 32'd0);
    steps(hold);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int hold [NC];
  int seen_at;

  initial begin
    model_reset();

    // 1: reset held with all sensors high, then released.
    fall_sensor = '1;
    steps(3);
    check_eq("s1.rst_warn",  32'(warn),  32'd0);
    check_eq("s1.rst_alarm", 32'(alarm), 32'd0);
    #2 reset_n = 1'b1;
    steps(7 + WARN_CYC - 1);
    check_eq("s1.warn_before", 32'(warn), 32'd0);
    step();
    check_eq("s1.warn_at20", 32'(warn), 32'hF);
    patient_reset = '1;
    step();
    patient_reset = '0;
    check_eq("s1.cancel_all", 32'(cancel_pulse), 32'hF);
    fall_sensor = '0;
    steps(12);

    // 2: ch0 warns at 20, patient cancels at 25.
    fall_sensor[0] = 1'b1;
    steps(7 + WARN_CYC - 1);
    check_eq("s2.warn0_19", 32'(warn[0]), 32'd0);
    step();
    check_eq("s2.warn0_20", 32'(warn[0]), 32'd1);
    steps(5);
    patient_reset[0] = 1'b1;
    step();
    patient_reset[0] = 1'b0;
    check_eq("s2.cancel0", 32'(cancel_pulse[0]), 32'd1);
    check_eq("s2.warn0_off", 32'(warn[0]), 32'd0);
    step();
    check_eq("s2.cancel0_1cyc", 32'(cancel_pulse[0]), 32'd0);
    steps(12);
    fall_sensor[0] = 1'b0;
    steps(10);
    check_eq("s2.no_alarm", 32'(alarm), 32'd0);

    // 3: ch1 latches alarm; patient ignored; ack clears; no re-entry on level.
    fall_sensor[1] = 1'b1;
    steps(7 + ALARM_CYC - 1);
    check_eq("s3.warn1_29",  32'(warn[1]),  32'd1);
    check_eq("s3.alarm1_29", 32'(alarm[1]), 32'd0);
    step();
    check_eq("s3.alarm1_30", 32'(alarm[1]), 32'd1);
    check_eq("s3.warn1_30",  32'(warn[1]),  32'd0);
    check_eq("s3.count",     32'(alarm_count), 32'd1);
    check_eq("s3.any",       32'(alarm_any),   32'd1);
    patient_reset[1] = 1'b1;
    steps(3);
    patient_reset[1] = 1'b0;
    check_eq("s3.latched", 32'(alarm[1]), 32'd1);
    caregiver_ack[1] = 1'b1;
    step();
    caregiver_ack[1] = 1'b0;
    check_eq("s3.acked", 32'(alarm[1]), 32'd0);
    steps(ALARM_CYC + 20);
    check_eq("s3.no_reentry", 32'(alarm[1] | warn[1]), 32'd0);
    fall_sensor[1] = 1'b0;
    steps(10);
    fall_sensor[1] = 1'b1;
    steps(7 + WARN_CYC);
    check_eq("s3.reentry_warn", 32'(warn[1]), 32'd1);
    fall_sensor[1] = 1'b0;
    steps(12);

    // 4: short glitches never start a fall; auto-clear cancel at 15.
    repeat (5) begin
      fall_sensor[2] = 1'b1;
      steps(3);
      fall_sensor[2] = 1'b0;
      steps(6);
    end
    steps(WARN_CYC + 5);
    check_eq("s4.glitch_warn", 32'(warn[2]), 32'd0);
    fall_sensor[2] = 1'b1;
    steps(7 + 15);
    fall_sensor[2] = 1'b0;
    seen_at = 99;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (cancel_pulse[2] && seen_at == 99) seen_at = i;
    end
    check_eq("s4.autoclear_lat", 32'(seen_at), 32'd7);

    // 5: ch0 and ch2 alarm together; ch3 cancelled on the alarm edge.
    fall_sensor = 4'b1101;
    steps(7 + ALARM_CYC - 1);
    patient_reset[3] = 1'b1;
    step();
    patient_reset[3] = 1'b0;
    check_eq("s5.alarm_vec", 32'(alarm),        32'b0101);
    check_eq("s5.count2",    32'(alarm_count),  32'd2);
    check_eq("s5.cancel3",   32'(cancel_pulse), 32'b1000);
    fall_sensor   = '0;
    caregiver_ack = 4'b0101;
    step();
    caregiver_ack = '0;
    steps(12);

    // 6: reset pulse while ch1 is in alarm.
    fall_sensor[1] = 1'b1;
    steps(7 + ALARM_CYC);
    check_eq("s6.alarm1", 32'(alarm[1]), 32'd1);
    async_reset(3);
    steps(20);
    fall_sensor = '0;
    steps(12);

    // Randomised traffic: mix of glitches, medium and long falls.
    for (int c = 0; c < NC; c++) hold[c] = $urandom_range(1, 40);
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NC; c++) begin
        if (hold[c] == 0) begin
          int r;
          fall_sensor[c] = ~fall_sensor[c];
          r = $urandom_range(0, 9);
          if (r < 3)      hold[c] = $urandom_range(1, 3);
          else if (r < 6) hold[c] = $urandom_range(5, 30);
          else            hold[c] = $urandom_range(31, 70);
        end else begin
          hold[c]--;
        end
        patient_reset[c] = ($urandom_range(0, 149) == 0);
        caregiver_ack[c] = ($urandom_range(0, 24) == 0);
      end
      if (t == 1500) async_reset(2);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
